// File: rtl/painter_row_sequencer_pkg.sv
// Shared definitions for the painter row sequencer: FSM state encodings,
// row geometry and the painter latency ceiling.
package painter_row_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_ADVANCE = 2'd3
   } state_t;

   localparam int ROW_LEN   = 64;
   localparam int COORD_W   = 6;
   localparam int MAX_DELAY = 15;

   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(ROW_LEN - 1);

   // True on the final column (also the final row index).
   function automatic logic is_last(input logic [COORD_W-1:0] i_v);
      return (i_v == LAST_COL);
   endfunction

endpackage

// File: rtl/painter_row_sequencer_valid_delay_line.sv
// Fixed-depth shift register carrying {valid, addr} alongside the painter
// pipeline so each rgb24 result is tagged with its column address.
module valid_delay_line #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 3
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   // Shift one stage per clock; reset flushes every stage.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // NOTE: every stage is cleared so an aborted row cannot leak a stale
         // valid out of the pipe after reset.
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/painter_row_sequencer.sv
// Row sequencer for a painter24-style pixel pipeline. Issues x = 0..63 for
// one row, tags each pixel with a valid delayed by the painter latency, and
// only advances y/subframe/frame once the row has fully drained.
// Optional feature: define FRAME_FREEZE_EN to add i_freeze, which holds the
// frame counter (and suppresses frame_tick) at a subframe wrap.
module painter_row_sequencer
   import painter_row_sequencer_pkg::*;
#(
   parameter int FRAME_BITS = 16,
   parameter int SUBFRAMES  = 256,
   parameter int DELAY      = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_row_req,
`ifdef FRAME_FREEZE_EN
   input  logic                  i_freeze,
`endif
   output logic                  o_row_ack,
   output logic [5:0]            o_row_y,
   output logic [5:0]            o_x,
   output logic [5:0]            o_y,
   output logic [FRAME_BITS-1:0] o_frame,
   output logic [7:0]            o_subframe,
   output logic                  o_wr_en,
   output logic [5:0]            o_wr_addr,
   output logic                  o_frame_tick
);

   localparam logic [7:0] SUB_LAST = 8'(SUBFRAMES - 1);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [COORD_W-1:0]      r_x;
   logic [COORD_W-1:0]      r_y;
   logic [FRAME_BITS-1:0]   r_frame;
   logic [7:0]              r_subframe;

   logic                    w_issue_valid;
   logic                    w_freeze;
   logic                    w_row_wrap;
   logic                    w_sub_wrap;
   logic                    w_frame_adv;
   logic [COORD_W:0]        w_dl_in;
   logic [COORD_W:0]        w_dl_out;

`ifdef FRAME_FREEZE_EN
   assign w_freeze = i_freeze;
`else
   assign w_freeze = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state and issue-valid decode.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      w_next_state  = r_state;
      w_issue_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_row_req) w_next_state = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_issue_valid = 1'b1;
            if (is_last(r_x)) w_next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Leave once the tagged result for the last column is emerging.
            if (w_dl_out[COORD_W] && is_last(w_dl_out[COORD_W-1:0]))
               w_next_state = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign w_row_wrap  = is_last(r_y);
   assign w_sub_wrap  = w_row_wrap && (r_subframe == SUB_LAST);
   assign w_frame_adv = (r_state == ST_ADVANCE) && w_sub_wrap && !w_freeze;

   // Column sweep and row/subframe/frame counters; painter inputs only move
   // between rows so in-flight pixels see stable values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_x        <= '0;
         r_y        <= '0;
         r_subframe <= '0;
         r_frame    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: r_x <= '0;
            ST_ISSUE: begin
               if (!is_last(r_x)) r_x <= r_x + 6'd1;
            end
            ST_ADVANCE: begin
               r_x <= '0;
               r_y <= r_y + 6'd1;
               if (w_row_wrap) begin
                  r_subframe <= w_sub_wrap ? 8'd0 : r_subframe + 8'd1;
               end
               if (w_frame_adv) r_frame <= r_frame + FRAME_BITS'(1);
            end
            default: ;
         endcase
      end
   end

   assign w_dl_in = {w_issue_valid, r_x};

   valid_delay_line #(
      .WIDTH (COORD_W + 1),
      .DEPTH (DELAY)
   ) u_delay (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_data  (w_dl_in),
      .o_data  (w_dl_out)
   );

   assign o_x          = r_x;
   assign o_y          = r_y;
   assign o_row_y      = r_y;
   assign o_frame      = r_frame;
   assign o_subframe   = r_subframe;
   assign o_wr_en      = w_dl_out[COORD_W];
   assign o_wr_addr    = w_dl_out[COORD_W-1:0];
   assign o_row_ack    = (r_state == ST_ADVANCE);
   assign o_frame_tick = w_frame_adv;

endmodule

// File: tb/tb_painter_row_sequencer.sv
// Bench for painter_row_sequencer. A small frame counter (2 bits) makes the
// all-ones -> 0 frame wrap reachable in a short run.
module tb_painter_row_sequencer;

   localparam int FRAME_BITS = 2;
   localparam int SUBFRAMES  = 2;
   localparam int DELAY      = 3;
   localparam int ROW_CYCLES = 66 + DELAY;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  row_req;
   logic                  freeze;
   logic                  row_ack;
   logic [5:0]            row_y;
   logic [5:0]            x;
   logic [5:0]            y;
   logic [FRAME_BITS-1:0] frame;
   logic [7:0]            subframe;
   logic                  wr_en;
   logic [5:0]            wr_addr;
   logic                  frame_tick;

   typedef struct packed {
      logic [5:0]            addr;
      logic [5:0]            y;
      logic [7:0]            sub;
      logic [FRAME_BITS-1:0] frame;
   } pix_t;

   pix_t                  sb_q[$];
   int                    checks = 0;
   int                    errors = 0;
   int                    ticks  = 0;
   logic [5:0]            m_y;
   logic [7:0]            m_sub;
   logic [FRAME_BITS-1:0] m_frame;

   always #5 clk = ~clk;

   painter_row_sequencer #(
      .FRAME_BITS (FRAME_BITS),
      .SUBFRAMES  (SUBFRAMES),
      .DELAY      (DELAY)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_row_req    (row_req),
`ifdef FRAME_FREEZE_EN
      .i_freeze     (freeze),
`endif
      .o_row_ack    (row_ack),
      .o_row_y      (row_y),
      .o_x          (x),
      .o_y          (y),
      .o_frame      (frame),
      .o_subframe   (subframe),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_frame_tick (frame_tick)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_y"},        y,        m_y);
      check({tag, "_row_y"},    row_y,    m_y);
      check({tag, "_subframe"}, subframe, m_sub);
      check({tag, "_frame"},    frame,    m_frame);
   endtask

   // Entered in IDLE at a falling edge with row_req=1 (row cycle 0); returns
   // at the IDLE cycle after row_ack, which is cycle 0 of the next row.
   task automatic do_row();
      pix_t exp;
      logic wrap;
      for (int k = 0; k < 64; k++)
         sb_q.push_back('{addr: 6'(k), y: m_y, sub: m_sub, frame: m_frame});
      wrap = (m_y == 6'd63) && (m_sub == 8'(SUBFRAMES - 1)) && !freeze;
      for (int c = 1; c <= ROW_CYCLES; c++) begin
         @(negedge clk);
         check("wr_en_timing", wr_en, (c >= 1 + DELAY) && (c <= 64 + DELAY));
         check("x", x, (c <= 64) ? c - 1 : ((c <= 65 + DELAY) ? 63 : 0));
         check("row_ack", row_ack, c == 65 + DELAY);
         check("frame_tick", frame_tick, (c == 65 + DELAY) && wrap);
         if (wr_en) begin
            check("sb_occupied", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               exp = sb_q.pop_front();
               check("wr_addr", wr_addr, exp.addr);
               check("pix_y", y, exp.y);
               check("pix_row_y", row_y, exp.y);
               check("pix_subframe", subframe, exp.sub);
               check("pix_frame", frame, exp.frame);
            end
         end
         if (c == 65 + DELAY) begin
            if (frame_tick) ticks++;
            if (m_y == 6'd63) begin
               if (m_sub == 8'(SUBFRAMES - 1)) begin
                  m_sub = 8'd0;
                  if (!freeze) m_frame = m_frame + 1'b1;
               end else begin
                  m_sub = m_sub + 8'd1;
               end
            end
            m_y = m_y + 6'd1;
         end
      end
      check("row_drained", sb_q.size(), 0);
      check_counters("after_row");
   endtask

   task automatic run_rows(input int n);
      for (int r = 0; r < n; r++) do_row();
   endtask

   initial begin
      int found;
      reset   = 1'b1;
      row_req = 1'b0;
      freeze  = 1'b0;
      m_y     = '0;
      m_sub   = '0;
      m_frame = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state.
      check("rst_row_ack", row_ack, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_frame_tick", frame_tick, 0);
      check("rst_x", x, 0);
      check_counters("rst");

      // row_req low: stays idle.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_wr_en", wr_en, 0);
         check("idle_row_ack", row_ack, 0);
         check("idle_x", x, 0);
      end

      // Back-to-back rows: y wraps and subframe steps at row 64, no tick.
      row_req = 1'b1;
      run_rows(64);
      check("wrap64_y", y, 0);
      check("wrap64_subframe", subframe, 1);
      check("wrap64_frame", frame, 0);
      check("wrap64_ticks", ticks, 0);

      // Frame tick on the 128th row_ack.
      run_rows(64);
      check("frame1_frame", frame, 1);
      check("frame1_subframe", subframe, 0);
      check("frame1_ticks", ticks, 1);

      // Three more frames: frame goes all-ones -> 0.
      run_rows(384);
      check("fwrap_frame", frame, 0);
      check("fwrap_ticks", ticks, 4);

`ifdef FRAME_FREEZE_EN
      // Frozen wrap: subframe/y wrap, frame held, no tick.
      freeze = 1'b1;
      run_rows(128);
      check("freeze_frame", frame, 0);
      check("freeze_subframe", subframe, 0);
      check("freeze_ticks", ticks, 4);
      freeze = 1'b0;
      run_rows(128);
      check("unfreeze_frame", frame, 1);
      check("unfreeze_ticks", ticks, 5);
`endif

      // Move counters off zero before the mid-row reset.
      run_rows(194);
      check("pre_abort_y", y, 2);
      check("pre_abort_subframe", subframe, 1);

      // Abort a row at wr_addr 30.
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(negedge clk);
         if (wr_en && wr_addr == 6'd30) found = 1;
      end
      check("reached_addr30", found, 1);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      row_req = 1'b0;
      sb_q.delete();
      m_y     = '0;
      m_sub   = '0;
      m_frame = '0;
      check("abort_wr_en", wr_en, 0);
      check("abort_row_ack", row_ack, 0);
      check("abort_x", x, 0);
      check("abort_wr_addr", wr_addr, 0);
      check_counters("abort");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_abort_wr_en", wr_en, 0);
         check("post_abort_row_ack", row_ack, 0);
      end

      // Restart from y=0, x=0.
      row_req = 1'b1;
      do_row();
      check("restart_y", y, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
